// File: rtl/wave_reg_file.sv
// CPU-visible register block and 16-byte wave RAM for the wave channel.
// Control fields are driven as static levels; trigger and length-load are one-cycle strobes.
module wave_reg_file #(
    parameter logic [7:0] REG_BASE  = 8'h1A,
    parameter logic [7:0] WAVE_BASE = 8'h30
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         apu_on,
    input  logic [7:0]   addr,
    input  logic [7:0]   wdata,
    input  logic         wr,
    input  logic         rd,
    output logic [7:0]   rdata,
    output logic         rd_valid,
    output logic         dac_en,
    output logic [1:0]   vol,
    output logic [7:0]   len_load,
    output logic         len_load_stb,
    output logic         len_enable,
    output logic [10:0]  freq,
    output logic         trigger,
    output logic [127:0] samples
);

    logic       dac_en_q, dac_en_d;
    logic [1:0] vol_q, vol_d;
    logic [7:0] len_load_q, len_load_d;
    logic       len_en_q, len_en_d;
    logic [2:0] freq_hi_q, freq_hi_d;
    logic [7:0] freq_lo_q, freq_lo_d;
    logic       trigger_q, trigger_d;
    logic       len_stb_q, len_stb_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rd_valid_q;
    logic [7:0] wave_q [16];

    logic [7:0] wave_off;
    logic       in_wave;
    logic       sel_nr30, sel_nr31, sel_nr32, sel_nr33, sel_nr34;
    logic       wr_reg;
    logic [7:0] rd_mux;

    assign wave_off = addr - WAVE_BASE;
    assign in_wave  = (wave_off < 8'd16);
    assign sel_nr30 = (addr == REG_BASE);
    assign sel_nr31 = (addr == REG_BASE + 8'd1);
    assign sel_nr32 = (addr == REG_BASE + 8'd2);
    assign sel_nr33 = (addr == REG_BASE + 8'd3);
    assign sel_nr34 = (addr == REG_BASE + 8'd4);
    // Register writes only land while the block is powered.
    assign wr_reg   = wr && apu_on;

    always_comb begin
        dac_en_d   = dac_en_q;
        vol_d      = vol_q;
        len_load_d = len_load_q;
        len_en_d   = len_en_q;
        freq_hi_d  = freq_hi_q;
        freq_lo_d  = freq_lo_q;
        if (!apu_on) begin
            dac_en_d   = 1'b0;
            vol_d      = 2'd0;
            len_load_d = 8'd0;
            len_en_d   = 1'b0;
            freq_hi_d  = 3'd0;
            freq_lo_d  = 8'd0;
        end else if (wr) begin
            if (sel_nr30) dac_en_d   = wdata[7];
            if (sel_nr31) len_load_d = wdata;
            if (sel_nr32) vol_d      = wdata[6:5];
            if (sel_nr33) freq_lo_d  = wdata;
            if (sel_nr34) begin
                len_en_d  = wdata[6];
                freq_hi_d = wdata[2:0];
            end
        end
    end

    // NR34 cannot change NR30 in the same cycle, so the held dac_en is the qualifying value.
    assign trigger_d = wr_reg && sel_nr34 && wdata[7] && dac_en_q;
    assign len_stb_d = wr_reg && sel_nr31;

    always_comb begin
        rd_mux = 8'hFF;
        if (sel_nr30)     rd_mux = {dac_en_q, 7'h7F};
        else if (sel_nr32) rd_mux = {1'b1, vol_q, 5'h1F};
        else if (sel_nr34) rd_mux = {1'b1, len_en_q, 6'h3F};
        else if (in_wave)  rd_mux = wave_q[wave_off[3:0]];
    end

    assign rdata_d = rd ? rd_mux : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_en_q   <= 1'b0;
            vol_q      <= 2'd0;
            len_load_q <= 8'd0;
            len_en_q   <= 1'b0;
            freq_hi_q  <= 3'd0;
            freq_lo_q  <= 8'd0;
            trigger_q  <= 1'b0;
            len_stb_q  <= 1'b0;
            rdata_q    <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            dac_en_q   <= dac_en_d;
            vol_q      <= vol_d;
            len_load_q <= len_load_d;
            len_en_q   <= len_en_d;
            freq_hi_q  <= freq_hi_d;
            freq_lo_q  <= freq_lo_d;
            trigger_q  <= trigger_d;
            len_stb_q  <= len_stb_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd;
        end
    end

    // Wave RAM lives in flops: it must clear on reset and feed all samples in parallel.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wave
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    wave_q[gi] <= 8'd0;
                else if (wr && in_wave && (wave_off[3:0] == gi[3:0]))
                    wave_q[gi] <= wdata;
            end
            assign samples[8*gi+3 -: 4] = wave_q[gi][7:4];
            assign samples[8*gi+7 -: 4] = wave_q[gi][3:0];
        end
    endgenerate

    assign rdata        = rdata_q;
    assign rd_valid     = rd_valid_q;
    assign dac_en       = dac_en_q;
    assign vol          = vol_q;
    assign len_load     = len_load_q;
    assign len_load_stb = len_stb_q;
    assign len_enable   = len_en_q;
    assign freq         = {freq_hi_q, freq_lo_q};
    assign trigger      = trigger_q;

endmodule

// File: doc/wave_reg_file.md
Name: wave_reg_file

Overview:
- Register and wave-RAM front end for the wave channel.
- Decodes CPU bus writes and reads for NR30–NR34 (FF1A–FF1E) and wave RAM (FF30–FF3F).
- Holds the channel control fields and drives them to the wave channel as static levels, plus single-cycle trigger and length-load strobes.
- Sits between the CPU/bus arbiter and the wave channel generator.

Parameters:
- REG_BASE, 8'h1A, low address byte of NR30; NR31–NR34 follow at +1..+4.
- WAVE_BASE, 8'h30, low address byte of wave RAM byte 0; 16 bytes.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- apu_on  in  1  NR52 master power; low = register block powered down.
- addr  in  8  low byte of CPU address (FF00 + addr).
- wdata  in  8  write data.
- wr  in  1  write strobe, one cycle per access.
- rd  in  1  read strobe, one cycle per access.
- rdata  out  8  read data, valid when rd_valid is high.
- rd_valid  out  1  one-cycle pulse, one cycle after rd.
- dac_en  out  1  NR30 bit 7.
- vol  out  2  NR32 bits 6:5.
- len_load  out  8  NR31 value; length counter counts 256 − len_load.
- len_load_stb  out  1  one-cycle pulse on any NR31 write.
- len_enable  out  1  NR34 bit 6.
- freq  out  11  {NR34[2:0], NR33}.
- trigger  out  1  one-cycle pulse on an NR34 write with bit 7 = 1.
- samples  out  128  wave table; sample i occupies bits [4i+3:4i].

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers and all 16 wave RAM bytes clear to 0.
  - All outputs are 0, including rdata, rd_valid and both strobes.
- Write (wr high, rising clk):
  - The addressed field updates on that edge.
  - Outputs reflect the new value in the same cycle as the edge, i.e. registered with no extra stage.
  - Unmapped addresses are ignored.
- Field capture:
  - NR30 stores bit 7 only.
  - NR31 stores all 8 bits.
  - NR32 stores bits 6:5.
  - NR33 stores 8 bits.
  - NR34 stores bit 6 and bits 2:0.
  - NR34 bit 7 is never stored.
- Strobes:
  - trigger is high for exactly the one cycle after an NR34 write with wdata[7] = 1.
  - len_load_stb behaves the same way for any NR31 write.
  - Back-to-back writes give back-to-back pulses; there is no merging or stretching.
- Trigger qualification: a trigger is suppressed (no pulse) if dac_en is 0 after the same write cycle.
  - dac_en is NR30, so this is the value from a prior write.
- Wave RAM packing: byte k (address WAVE_BASE + k) holds sample 2k in bits 7:4 and sample 2k+1 in bits 3:0.
  - Example: write FF30 = 8'hA5 gives samples[3:0] = 4'hA and samples[7:4] = 4'h5.
- Read:
  - rd at cycle N gives rd_valid and rdata at cycle N+1.
  - rdata holds until the next read.
- Read-back values (register OR mask):
  - NR30 = stored | 8'h7F.
  - NR31 = 8'hFF (write-only).
  - NR32 = stored | 8'h9F.
  - NR33 = 8'hFF (write-only).
  - NR34 = stored | 8'hBF.
  - Wave RAM returns the stored byte.
  - Unmapped addresses return 8'hFF.
- Simultaneous rd and wr to the same address: read returns the pre-write value.
- Power-down (apu_on low), level-sensitive and synchronous:
  - NR30–NR34 clear to 0 on the next edge and stay 0.
  - Writes to NR30–NR34 are ignored while apu_on is low.
  - Wave RAM is retained and remains readable and writable.
  - Strobes are not generated.
- apu_on rising: no side effects; registers remain 0 until written.
- Reset asserted mid-access: the pending rd_valid is dropped and the strobe is cancelled immediately.

Test Plan:
- Reset, then read FF1A, FF1C, FF1E, FF1B and FF27 → rd_valid one cycle after each rd; rdata = 7F, 9F, BF, FF, FF; all outputs 0.
- Write FF1A = 80, FF1C = 40, FF1D = 34, FF1E = C5 → dac_en = 1, vol = 2, freq = 11'h534, len_enable = 1, trigger high exactly one cycle; read FF1E = FF.
- With dac_en = 0, write FF1E = 80 → no trigger pulse; freq[10:8] = 0. Write FF1B = 3F twice in consecutive cycles → len_load = 3F, len_load_stb high for 2 consecutive cycles.
- Write FF30 = A5 and FF3F = 1E → samples[3:0] = A, samples[7:4] = 5, samples[123:120] = 1, samples[127:124] = E. Read FF30 with a simultaneous write of 00 → rdata = A5; next read = 00.
- Load fields, drop apu_on, write FF1C = 60 and FF31 = 77 → vol stays 0, all NR fields 0, wave byte 1 = 77 and readable. Raise apu_on → fields still 0.
- Assert rst_n low asynchronously between clock edges while trigger is high → trigger, rd_valid and all fields go to 0 without waiting for clk.
